// File: rtl/tone_decoder.sv
// tone_decoder: counts rising edges of a square wave over a GATE_MS gate and classifies the note (C4..C5).
// Optional build macro TONE_DECODER_HYST_EN: note/led only change after two consecutive matching windows.
module tone_decoder #(
    parameter int GATE_MS = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_milli,
    input  logic        sound_in,
    output logic [15:0] freq_hz,
    output logic [3:0]  note,
    output logic        note_valid,
    output logic [7:0]  led
);
    localparam int          SCALE     = 1000 / GATE_MS;
    localparam logic [15:0] GATE_LAST = 16'(GATE_MS - 1);

    typedef enum logic [1:0] {MEASURE, CALC, PUBLISH} state_t;

    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic [3:0] classify(input logic [15:0] f);
        if (f < 16'd247)      return 4'd15;
        else if (f <= 16'd277) return 4'd0;
        else if (f <= 16'd311) return 4'd1;
        else if (f <= 16'd339) return 4'd2;
        else if (f <= 16'd370) return 4'd3;
        else if (f <= 16'd415) return 4'd4;
        else if (f <= 16'd466) return 4'd5;
        else if (f <= 16'd508) return 4'd6;
        else if (f <= 16'd540) return 4'd7;
        else                   return 4'd15;
    endfunction

    function automatic logic [7:0] seg(input logic [3:0] n);
        case (n)
            4'd0:    return 8'h39;
            4'd1:    return 8'h5E;
            4'd2:    return 8'h79;
            4'd3:    return 8'h71;
            4'd4:    return 8'h3D;
            4'd5:    return 8'h77;
            4'd6:    return 8'h7C;
            4'd7:    return 8'hB9;
            default: return 8'h40;
        endcase
    endfunction

    logic        sync1_q, sync2_q, dly_q;
    logic [15:0] ms_cnt_q, ms_cnt_d;
    logic [15:0] gate_cnt_q, gate_cnt_d;
    logic [15:0] edge_cnt_q, edge_cnt_d;
    logic [15:0] win_cnt_q, win_cnt_d;
    logic [15:0] edge_sum;
    logic [15:0] f_d;
    logic [3:0]  cls_d;
    logic        edge_det, ms_wrap, gate_end;
    state_t      state_q;
    logic [15:0] freq_q;
    logic [3:0]  note_q;
    logic [7:0]  led_q;
    logic        valid_q;
`ifdef TONE_DECODER_HYST_EN
    logic [3:0]  prev_cls_q;
`endif

    assign edge_det = sync2_q & ~dly_q;

    // Timebase, gate and edge accumulation; the gate-end edge is folded into the captured window count.
    always_comb begin
        ms_wrap  = (ticks_per_milli != 16'd0) && (ms_cnt_q >= ticks_per_milli - 16'd1);
        gate_end = ms_wrap && (gate_cnt_q >= GATE_LAST);

        ms_cnt_d = ms_cnt_q + 16'd1;
        if ((ticks_per_milli == 16'd0) || ms_wrap)
            ms_cnt_d = 16'd0;

        gate_cnt_d = gate_cnt_q;
        if (ms_wrap)
            gate_cnt_d = gate_end ? 16'd0 : gate_cnt_q + 16'd1;

        edge_sum   = sat16({16'd0, edge_cnt_q} + {31'd0, edge_det});
        edge_cnt_d = gate_end ? 16'd0 : edge_sum;
        win_cnt_d  = gate_end ? edge_sum : win_cnt_q;

        f_d   = sat16({16'd0, win_cnt_q} * 32'(SCALE));
        cls_d = classify(f_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            dly_q      <= 1'b0;
            ms_cnt_q   <= 16'd0;
            gate_cnt_q <= 16'd0;
            edge_cnt_q <= 16'd0;
        end else begin
            sync1_q    <= sound_in;
            sync2_q    <= sync1_q;
            dly_q      <= sync2_q;
            ms_cnt_q   <= ms_cnt_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    // Window count is plain data: a stale value is never published because reset returns the FSM to MEASURE.
    always_ff @(posedge clk) begin
        win_cnt_q <= win_cnt_d;
    end

    // Outputs are registered at the end of CALC so they appear together with the PUBLISH pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MEASURE;
            freq_q     <= 16'd0;
            note_q     <= 4'd15;
            led_q      <= 8'h40;
            valid_q    <= 1'b0;
`ifdef TONE_DECODER_HYST_EN
            prev_cls_q <= 4'd15;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                MEASURE: begin
                    if (gate_end)
                        state_q <= CALC;
                end
                CALC: begin
                    freq_q  <= f_d;
                    valid_q <= 1'b1;
`ifdef TONE_DECODER_HYST_EN
                    if (cls_d == prev_cls_q) begin
                        note_q <= cls_d;
                        led_q  <= seg(cls_d);
                    end
                    prev_cls_q <= cls_d;
`else
                    note_q <= cls_d;
                    led_q  <= seg(cls_d);
`endif
                    state_q <= PUBLISH;
                end
                PUBLISH: state_q <= MEASURE;
                default: state_q <= MEASURE;
            endcase
        end
    end

    assign freq_hz    = freq_q;
    assign note       = note_q;
    assign led        = led_q;
    assign note_valid = valid_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Scoreboard bench for tone_decoder: random and directed tones, expected results from an edge-counting window model.
module tb_tone_decoder;
    localparam int GATE_MS = 100;
    localparam int SCALE   = 1000 / GATE_MS;
    localparam int LO[8]   = '{247, 278, 312, 340, 371, 416, 467, 509};
    localparam int SEG[8]  = '{'h39, 'h5E, 'h79, 'h71, 'h3D, 'h77, 'h7C, 'hB9};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sound_in = 1'b0;
    logic [15:0] ticks_per_milli = 16'd100;
    logic [15:0] freq_hz;
    logic [3:0]  note;
    logic        note_valid;
    logic [7:0]  led;

    tone_decoder #(.GATE_MS(GATE_MS)) dut (
        .clk(clk),
        .rst(rst),
        .ticks_per_milli(ticks_per_milli),
        .sound_in(sound_in),
        .freq_hz(freq_hz),
        .note(note),
        .note_valid(note_valid),
        .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e_cyc;
        int e_freq;
        int e_note;
        int e_led;
    } exp_t;

    exp_t sb[$];
    int   det_q[$];
    int   cyc = 0;
    logic rst_s = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    int p0 = 0, win_end = 0, n_win = 0;
    int m_note = 15, m_prev = 15;
    int per = 0, hi = 0, ph = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    function automatic int model_note(input int f);
        int r;
        r = 15;
        if (f <= 540)
            for (int i = 0; i < 8; i++)
                if (f >= LO[i]) r = i;
        return r;
    endfunction

    function automatic int model_led(input int n);
        return (n == 15) ? 'h40 : SEG[n];
    endfunction

    // A window's result is the number of input rises seen inside it, times SCALE.
    task automatic close_window();
        int   n;
        int   f;
        int   cls;
        exp_t e;
        n = 0;
        while (det_q.size() > 0 && det_q[0] <= win_end) begin
            void'(det_q.pop_front());
            n++;
        end
        if (n > 65535) n = 65535;
        f = n * SCALE;
        if (f > 65535) f = 65535;
        cls = model_note(f);
`ifdef TONE_DECODER_HYST_EN
        if (cls == m_prev) m_note = cls;
        m_prev = cls;
`else
        m_note = cls;
`endif
        e.e_cyc  = win_end + 1;
        e.e_freq = f;
        e.e_note = m_note;
        e.e_led  = model_led(m_note);
        sb.push_back(e);
        win_end += n_win;
    endtask

    // A rise driven before posedge k is counted by the decoder at posedge k+2.
    task automatic step();
        @(negedge clk);
        if (per > 0) begin
            ph = (ph + 1) % per;
            if (ph >= per - hi) begin
                if (!sound_in) det_q.push_back(cyc + 3);
                sound_in = 1'b1;
            end else begin
                sound_in = 1'b0;
            end
        end else begin
            sound_in = 1'b0;
        end
        if (n_win > 0 && cyc == win_end) close_window();
    endtask

    task automatic set_tone(input int p, input int h);
        per = p;
        hi  = h;
        ph  = 0;
    endtask

    task automatic do_reset(input int tpm);
        rst = 1'b1;
        sound_in = 1'b0;
        ticks_per_milli = 16'(tpm);
        @(negedge clk);
        rst = 1'b0;
        p0 = cyc;
        n_win = GATE_MS * tpm;
        win_end = p0 + n_win;
        det_q.delete();
        ph = 0;
        m_note = 15;
        m_prev = 15;
    endtask

    initial begin
        int p;
        int h;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        do_reset(100);
        set_tone(227, 113);
        repeat (10010) step();
        repeat (4990) step();
        do_reset(100);
        repeat (10010) step();

        set_tone(0, 0);
        do_reset(10);
        repeat (3010) step();

        set_tone(38, 19);
        do_reset(10);
        repeat (3010) step();

        set_tone(4, 2);
        do_reset(100);
        repeat (10010) step();

        do_reset(10);
        for (int w = 0; w < 15; w++) begin
            p = int'($urandom_range(60, 16));
            h = int'($urandom_range(p - 2, 2));
            set_tone(p, h);
            repeat (1000) step();
        end
        repeat (10) step();

        do_reset(0);
        set_tone(30, 15);
        repeat (500) step();

        done = 1'b1;
        repeat (5) @(negedge clk);
        $display("FAIL monitor_end: summary not reached");
        $fatal(1, "bench did not terminate");
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_s) begin
            checks++;
            if (freq_hz != 16'd0 || note != 4'd15 || led != 8'h40 || note_valid) begin
                errors++;
                $display("FAIL reset_values: got freq=%0d note=%0d led=%h valid=%b, want 0/15/40/0",
                         freq_hz, note, led, note_valid);
            end
        end
        if (sb.size() > 0 && cyc > sb[0].e_cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_pulse: no note_valid at cycle %0d (now %0d)", sb[0].e_cyc, cyc);
            void'(sb.pop_front());
        end
        if (note_valid) begin
            checks++;
            if (sb.size() == 0 || sb[0].e_cyc != cyc) begin
                errors++;
                $display("FAIL pulse_timing: note_valid at cycle %0d, want cycle %0d",
                         cyc, (sb.size() > 0) ? sb[0].e_cyc : -1);
            end else begin
                e = sb.pop_front();
                checks++;
                if (int'(freq_hz) != e.e_freq) begin
                    errors++;
                    $display("FAIL freq_hz: got %0d want %0d at cycle %0d", freq_hz, e.e_freq, cyc);
                end
                checks++;
                if (int'(note) != e.e_note) begin
                    errors++;
                    $display("FAIL note: got %0d want %0d at cycle %0d", note, e.e_note, cyc);
                end
                checks++;
                if (int'(led) != e.e_led) begin
                    errors++;
                    $display("FAIL led: got %h want %h at cycle %0d", led, e.e_led, cyc);
                end
            end
        end
        if (done) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL pending_results: got %0d undelivered, want 0", sb.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

endmodule
